// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between instruction fetch (IF) and data
// load/store (D).
//
// The arbiter grants one request at a time. When both requesters ask at once, the one that
// was not served last wins. It drives a single memory transaction for the granted request
// and returns the read data together with a one-cycle done pulse. Misaligned word accesses
// and memory timeouts finish early, with err asserted and the returned data set to 0.
//
// Ports:
//   i_clk_50, i_rst_n                   clock; synchronous active-low reset
//   i_if_req, i_if_addr                 fetch request (word read)
//   o_if_done, o_if_rdata               fetch done pulse / fetched word
//   i_d_req, i_d_addr, i_d_wdata,
//   i_d_rw, i_d_datasize                data request (rw: 1=write; datasize: 1=byte)
//   o_d_done, o_d_rdata                 data done pulse / load data
//   o_err                               pulses with a done for misalignment or timeout
//   o_mem_en, o_mem_addr, o_mem_wdata,
//   o_mem_rw, o_mem_datasize            memory request (en is a one-cycle start strobe)
//   i_mem_r, i_mem_rdata                memory ready / read data
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        i_clk_50,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_done,
  output logic [15:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic [15:0] i_d_addr,
  input  logic [15:0] i_d_wdata,
  input  logic        i_d_rw,
  input  logic        i_d_datasize,
  output logic        o_d_done,
  output logic [15:0] o_d_rdata,
  output logic        o_err,
  output logic        o_mem_en,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_rw,
  output logic        o_mem_datasize,
  input  logic        i_mem_r,
  input  logic [15:0] i_mem_rdata
);

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_last_d;     // last grant went to D
  logic        r_owner_d;    // current access belongs to D
  logic        r_err;
  logic [7:0]  r_timer;
  logic [15:0] r_mem_addr, r_mem_wdata;
  logic        r_mem_rw, r_mem_ds;
  logic [15:0] r_if_rdata, r_d_rdata;

  logic        w_grant_d;
  logic [15:0] w_req_addr;
  logic [15:0] w_req_wdata;
  logic        w_req_rw, w_req_byte, w_misaligned;
  logic [7:0]  w_timer_inc;
  logic        w_grant, w_to_done, w_done_err, w_done_owner_d;
  logic [15:0] w_done_data;

  // Round robin: on a tie, D wins only when IF was served last.
  assign w_grant_d    = i_d_req && (!i_if_req || !r_last_d);
  assign w_req_addr   = w_grant_d ? i_d_addr : i_if_addr;
  assign w_req_rw     = w_grant_d && i_d_rw;
  assign w_req_byte   = w_grant_d && i_d_datasize;
  assign w_misaligned = !w_req_byte && w_req_addr[0];
  // Byte stores replicate the low byte so either lane of the memory sees it.
  assign w_req_wdata  = !w_grant_d ? r_mem_wdata :
                        (w_req_byte ? {i_d_wdata[7:0], i_d_wdata[7:0]} : i_d_wdata);
  assign w_timer_inc  = r_timer + 8'd1;
  // A misaligned access reaches DONE straight from IDLE, before the owner is latched.
  assign w_done_owner_d = (r_state == StIdle) ? w_grant_d : r_owner_d;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_to_done    = 1'b0;
    w_done_err   = 1'b0;
    w_done_data  = 16'h0000;
    unique case (r_state)
      StIdle: begin
        if (i_if_req || i_d_req) begin
          w_grant = 1'b1;
          if (w_misaligned) begin
            w_state_next = StDone;
            w_to_done    = 1'b1;
            w_done_err   = 1'b1;
          end else begin
            w_state_next = StIssue;
          end
        end
      end
      StIssue: w_state_next = StWait;
      StWait: begin
        if (i_mem_r) begin
          w_state_next = StDone;
          w_to_done    = 1'b1;
          w_done_data  = r_mem_rw ? 16'h0000 : i_mem_rdata;
        end else if (w_timer_inc == TimeoutCnt) begin
          w_state_next = StDone;
          w_to_done    = 1'b1;
          w_done_err   = 1'b1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_50) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_last_d    <= 1'b1;
      r_owner_d   <= 1'b0;
      r_err       <= 1'b0;
      r_timer     <= 8'd0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_mem_rw    <= 1'b0;
      r_mem_ds    <= 1'b0;
      r_if_rdata  <= 16'h0000;
      r_d_rdata   <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last_d  <= w_grant_d;
        r_owner_d <= w_grant_d;
        // Memory-facing registers keep their old values for misaligned accesses.
        if (!w_misaligned) begin
          r_mem_addr  <= w_req_addr;
          r_mem_wdata <= w_req_wdata;
          r_mem_rw    <= w_req_rw;
          r_mem_ds    <= w_req_byte;
        end
      end
      if (r_state == StIssue) begin
        r_timer <= 8'd0;
      end else if (r_state == StWait && !i_mem_r) begin
        r_timer <= w_timer_inc;
      end
      if (w_to_done) begin
        r_err <= w_done_err;
        if (w_done_owner_d) r_d_rdata  <= w_done_data;
        else                r_if_rdata <= w_done_data;
      end
    end
  end

  assign o_if_done      = (r_state == StDone) && !r_owner_d;
  assign o_d_done       = (r_state == StDone) && r_owner_d;
  assign o_err          = (r_state == StDone) && r_err;
  assign o_if_rdata     = r_if_rdata;
  assign o_d_rdata      = r_d_rdata;
  assign o_mem_en       = (r_state == StIssue);
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_rw       = r_mem_rw;
  assign o_mem_datasize = r_mem_ds;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level
// model (round-robin owner choice, expected memory request, latency, done/err/rdata).
module tb_mem_arbiter;
  localparam int unsigned TO = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_rw = 1'b0, d_ds = 1'b0, mem_r = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_done, d_done, err, mem_en, mem_rw, mem_ds;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  // Model state: who was served last, and the rdata each requester should be holding.
  bit          m_last_d = 1'b1;
  logic [15:0] m_if_rdata = '0, m_d_rdata = '0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk_50(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_rw(d_rw),
    .i_d_datasize(d_ds), .o_d_done(d_done), .o_d_rdata(d_rdata), .o_err(err),
    .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_rw(mem_rw),
    .o_mem_datasize(mem_ds), .i_mem_r(mem_r), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    {15'd0, mem_en}, 16'h0);
    chk({tag, "_done"},  {14'd0, if_done, d_done}, 16'h0);
    chk({tag, "_err"},   {15'd0, err}, 16'h0);
    chk({tag, "_ifrd"},  if_rdata, 16'h0);
    chk({tag, "_drd"},   d_rdata, 16'h0);
    chk({tag, "_addr"},  mem_addr, 16'h0);
    chk({tag, "_wdata"}, mem_wdata, 16'h0);
    chk({tag, "_ctl"},   {14'd0, mem_rw, mem_ds}, 16'h0);
  endtask

  // Serves one access. Call in an IDLE cycle with at least one request already driven.
  // delay: WAIT cycle in which mem_r rises (> TO means never). Returns in the next IDLE cycle.
  task automatic run_txn(input int delay, input logic [15:0] rd, input bit drop_early);
    bit          own_d, wr, bs, mis, timed_out;
    logic [15:0] a, ew, er;
    own_d = (if_req && d_req) ? !m_last_d : d_req;
    m_last_d = own_d;
    a  = own_d ? d_addr : if_addr;
    wr = own_d && d_rw;
    bs = own_d && d_ds;
    mis = !bs && a[0];
    ew = bs ? {d_wdata[7:0], d_wdata[7:0]} : d_wdata;
    timed_out = 1'b0;
    tick();  // grant edge
    if (drop_early) begin
      // Owner's inputs must already be latched; scramble them.
      if (own_d) begin
        d_req = 1'b0; d_addr = 16'($urandom); d_wdata = 16'($urandom);
        d_rw = ~d_rw; d_ds = ~d_ds;
      end else begin
        if_req = 1'b0; if_addr = 16'($urandom);
      end
    end
    if (!mis) begin
      chk("issue_en",   {15'd0, mem_en}, 16'h1);
      chk("issue_addr", mem_addr, a);
      chk("issue_rw",   {15'd0, mem_rw}, {15'd0, wr});
      chk("issue_ds",   {15'd0, mem_ds}, {15'd0, bs});
      if (wr) chk("issue_wdata", mem_wdata, ew);
      chk("issue_done", {14'd0, if_done, d_done}, 16'h0);
      mem_r = 1'($urandom_range(0, 1));  // must be ignored in ISSUE
      mem_rdata = 16'($urandom);
      for (int w = 1; w <= int'(TO); w++) begin
        tick();
        mem_r = 1'b0;
        chk("wait_en",   {15'd0, mem_en}, 16'h0);
        chk("wait_addr", mem_addr, a);
        chk("wait_done", {14'd0, if_done, d_done}, 16'h0);
        if (w == delay) begin
          mem_r = 1'b1;
          mem_rdata = rd;
          break;
        end
      end
      timed_out = (delay > int'(TO));
      tick();  // done edge
    end
    er = (mis || timed_out || wr) ? 16'h0 : rd;
    if (own_d) m_d_rdata = er; else m_if_rdata = er;
    chk("done_if",  {15'd0, if_done}, {15'd0, !own_d});
    chk("done_d",   {15'd0, d_done},  {15'd0, own_d});
    chk("done_err", {15'd0, err}, {15'd0, (mis || timed_out)});
    chk("done_en",  {15'd0, mem_en}, 16'h0);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata",  d_rdata,  m_d_rdata);
    mem_r = 1'($urandom_range(0, 1));  // ignored in DONE/IDLE
    mem_rdata = 16'($urandom);
    if (own_d) d_req = 1'b0; else if_req = 1'b0;
    tick();  // back in IDLE
    chk("idle_done", {14'd0, if_done, d_done}, 16'h0);
    chk("idle_en",   {15'd0, mem_en}, 16'h0);
    chk("idle_ifrd", if_rdata, m_if_rdata);
    chk("idle_drd",  d_rdata,  m_d_rdata);
    mem_r = 1'b0;
  endtask

  initial begin
    int p;
    // Reset with both requests high.
    if_req = 1'b1; d_req = 1'b1; if_addr = 16'h3000; d_addr = 16'h4000;
    tick();
    chk_all_zero("rst1");
    tick();
    chk_all_zero("rst2");
    rst_n = 1'b1;

    // Tie right after reset: IF first, then D, then alternate again.
    for (int r = 0; r < 2; r++) begin
      if_req = 1'b1; d_req = 1'b1;
      if_addr = 16'h3000 + 16'(r * 2); d_addr = 16'h5000; d_rw = 1'b0; d_ds = 1'b0;
      run_txn(2, 16'hAAA0 + 16'(r), 1'b0);
      chk("tie_second_is_d", {15'd0, m_last_d}, 16'h0);  // model must have picked IF first
      run_txn(3, 16'hBBB0 + 16'(r), 1'b0);
    end

    // Fetch at 0x3000, memory ready in the fifth WAIT cycle.
    if_req = 1'b1; if_addr = 16'h3000;
    run_txn(5, 16'h1234, 1'b0);
    chk("fetch_rdata", if_rdata, 16'h1234);

    // Byte store to an odd address.
    d_req = 1'b1; d_addr = 16'h4001; d_wdata = 16'h00A7; d_rw = 1'b1; d_ds = 1'b1;
    run_txn(1, 16'hFFFF, 1'b0);

    // Misaligned word load.
    d_req = 1'b1; d_addr = 16'h4001; d_rw = 1'b0; d_ds = 1'b0;
    run_txn(1, 16'h5555, 1'b0);

    // Boundary: ready in the last allowed WAIT cycle, then a timeout.
    d_req = 1'b1; d_addr = 16'h6000;
    run_txn(int'(TO), 16'h7777, 1'b0);
    d_req = 1'b1; d_addr = 16'h6002;
    run_txn(int'(TO) + 5, 16'h8888, 1'b0);

    // Reset in the middle of WAIT: no done, everything back to zero.
    d_req = 1'b1; d_addr = 16'h6004;
    tick();
    tick();
    tick();
    rst_n = 1'b0; d_req = 1'b0; mem_r = 1'b1; mem_rdata = 16'h9999;
    tick();
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    m_last_d = 1'b1; m_if_rdata = '0; m_d_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_done", {14'd0, if_done, d_done}, 16'h0);
      chk("post_rst_en",   {15'd0, mem_en}, 16'h0);
    end
    mem_r = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      p = int'($urandom_range(0, 2));
      if_addr = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 5) == 0) if_addr[0] = 1'b1;
      d_addr = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 5) == 0) d_addr[0] = 1'b1;
      d_wdata = 16'($urandom);
      d_rw = 1'($urandom_range(0, 1));
      d_ds = 1'($urandom_range(0, 1));
      if_req = (p != 1);
      d_req  = (p != 0);
      run_txn(int'($urandom_range(1, TO + 1)), 16'($urandom), ($urandom_range(0, 3) == 0));
      if (p == 2) run_txn(int'($urandom_range(1, TO + 1)), 16'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
